// File: rtl/i2s_rx_dc_fifo_pkg.sv
// Shared constants and pointer helpers for the I2S RX dual-clock FIFO.
package i2s_rx_dc_fifo_pkg;

    localparam int unsigned I2S_DATA_WIDTH = 32;

    // Upper bound on pointer width handled by the gray helpers.
    localparam int unsigned PTR_MAX_W = 16;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return 32'($clog2(depth)) + 32'd1;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Prefix-XOR from the MSB down; zero-extended inputs decode correctly.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
        logic [PTR_MAX_W-1:0] bin;
        bin = gray;
        for (int s = 1; s < int'(PTR_MAX_W); s = s * 2) begin
            bin = bin ^ (bin >> s);
        end
        return bin;
    endfunction

endpackage

// File: rtl/i2s_rx_dc_fifo_ptr_sync.sv
// Multi-flop synchronizer for a gray-coded pointer crossing into the clk domain.
module i2s_dc_ptr_sync #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [STAGES*WIDTH-1:0] chain;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            chain <= '0;
        end else begin
            chain <= {chain[(STAGES-1)*WIDTH-1:0], din};
        end
    end

    assign dout = chain[STAGES*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/i2s_rx_dc_fifo.sv
// Dual-clock FWFT FIFO carrying I2S RX words from sck to the system clock.
// Optional dst_level_o occupancy output under I2S_RX_DC_FIFO_LEVEL_EN.
module i2s_rx_dc_fifo
    import i2s_rx_dc_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = I2S_DATA_WIDTH,
    parameter int unsigned BUFFER_DEPTH = 4,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                          src_clk_i,
    input  logic                          dst_clk_i,
    input  logic                          rstn_i,
    input  logic [DATA_WIDTH-1:0]         src_data_i,
    input  logic                          src_valid_i,
    output logic                          src_ready_o,
    output logic [DATA_WIDTH-1:0]         dst_data_o,
    output logic                          dst_valid_o,
    input  logic                          dst_ready_i
`ifdef I2S_RX_DC_FIFO_LEVEL_EN
    ,
    output logic [$clog2(BUFFER_DEPTH):0] dst_level_o
`endif
);

    localparam int unsigned PW = ptr_width(BUFFER_DEPTH);
    localparam int unsigned AW = PW - 1;
    // Gray full pattern: top two bits inverted relative to the read pointer.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

    logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];

    logic [PW-1:0] wptr_bin;
    logic [PW-1:0] wptr_gray;
    logic [PW-1:0] wptr_bin_nxt;
    logic [PW-1:0] rptr_gray_sync;
    logic          full;
    logic          wr_en;

    logic [PW-1:0] rptr_bin;
    logic [PW-1:0] rptr_gray;
    logic [PW-1:0] rptr_bin_nxt;
    logic [PW-1:0] wptr_gray_sync;
    logic          empty;
    logic          rd_en;

    // Write side (src_clk_i)
    assign full         = (wptr_gray == (rptr_gray_sync ^ FULL_MASK));
    assign wr_en        = src_valid_i & ~full;
    assign wptr_bin_nxt = wptr_bin + PW'(1);
    assign src_ready_o  = ~full;

    always_ff @(posedge src_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr_bin  <= '0;
            wptr_gray <= '0;
        end else if (wr_en) begin
            wptr_bin  <= wptr_bin_nxt;
            wptr_gray <= PW'(bin2gray(PTR_MAX_W'(wptr_bin_nxt)));
        end
    end

    // Storage is intentionally left unreset.
    always_ff @(posedge src_clk_i) begin
        if (wr_en) begin
            mem[wptr_bin[AW-1:0]] <= src_data_i;
        end
    end

    // Read side (dst_clk_i)
    assign empty        = (rptr_gray == wptr_gray_sync);
    assign dst_valid_o  = ~empty;
    assign rd_en        = dst_ready_i & ~empty;
    assign rptr_bin_nxt = rptr_bin + PW'(1);
    assign dst_data_o   = mem[rptr_bin[AW-1:0]];

    always_ff @(posedge dst_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rptr_bin  <= '0;
            rptr_gray <= '0;
        end else if (rd_en) begin
            rptr_bin  <= rptr_bin_nxt;
            rptr_gray <= PW'(bin2gray(PTR_MAX_W'(rptr_bin_nxt)));
        end
    end

    i2s_dc_ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk    (dst_clk_i),
        .rstn_i (rstn_i),
        .din    (wptr_gray),
        .dout   (wptr_gray_sync)
    );

    i2s_dc_ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk    (src_clk_i),
        .rstn_i (rstn_i),
        .din    (rptr_gray),
        .dout   (rptr_gray_sync)
    );

`ifdef I2S_RX_DC_FIFO_LEVEL_EN
    // Occupancy as seen from the dst domain, one cycle behind the pointers.
    always_ff @(posedge dst_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            dst_level_o <= '0;
        end else begin
            dst_level_o <= PW'(gray2bin(PTR_MAX_W'(wptr_gray_sync))) - rptr_bin;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_rx_dc_fifo.sv
// Scoreboard bench for i2s_rx_dc_fifo: directed writes push expectations, a dst monitor pops.
`timescale 1ns/1ps
module tb_i2s_rx_dc_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = 3;

    logic          src_clk;
    logic          dst_clk;
    logic          rstn;
    logic [DW-1:0] src_data;
    logic          src_valid;
    logic          src_ready;
    logic [DW-1:0] dst_data;
    logic          dst_valid;
    logic          dst_ready;
`ifdef I2S_RX_DC_FIFO_LEVEL_EN
    logic [PW-1:0] dst_level;
`endif

    int src_half;
    int dst_half;
    bit src_run;
    bit rand_rdy;

    int errors;
    int checks;
    int pops;
    logic [DW-1:0] exp_q [$];

    i2s_rx_dc_fifo #(
        .DATA_WIDTH   (DW),
        .BUFFER_DEPTH (DEPTH),
        .SYNC_STAGES  (2)
    ) dut (
        .src_clk_i   (src_clk),
        .dst_clk_i   (dst_clk),
        .rstn_i      (rstn),
        .src_data_i  (src_data),
        .src_valid_i (src_valid),
        .src_ready_o (src_ready),
        .dst_data_o  (dst_data),
        .dst_valid_o (dst_valid),
        .dst_ready_i (dst_ready)
`ifdef I2S_RX_DC_FIFO_LEVEL_EN
        ,
        .dst_level_o (dst_level)
`endif
    );

    initial begin
        src_clk = 1'b0;
        forever begin
            #(src_half);
            if (src_run) src_clk = ~src_clk;
        end
    end

    initial begin
        dst_clk = 1'b0;
        forever #(dst_half) dst_clk = ~dst_clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: every accepted head word must match the oldest expectation.
    always @(negedge dst_clk) begin
        logic [DW-1:0] e;
        if (rstn && dst_valid && dst_ready) begin
            checks++;
            pops++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat: got %h required no beat", dst_data);
            end else begin
                e = exp_q.pop_front();
                if (dst_data !== e) begin
                    errors++;
                    $display("FAIL data: got %h required %h", dst_data, e);
                end
            end
        end
    end

    always @(posedge dst_clk) begin
        if (rand_rdy) begin
            #1;
            dst_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic wr(input logic [DW-1:0] d, input bit accept);
        @(negedge src_clk);
        src_data  = d;
        src_valid = 1'b1;
        if (accept) exp_q.push_back(d);
        @(negedge src_clk);
        src_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge dst_clk);
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout required completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int sent;
        int guard;
        int pops0;

        errors    = 0;
        checks    = 0;
        pops      = 0;
        src_half  = 500;
        dst_half  = 10;
        src_run   = 1'b1;
        rand_rdy  = 1'b0;
        src_data  = '0;
        src_valid = 1'b0;
        dst_ready = 1'b0;
        rstn      = 1'b0;

        #1;
        check("rst_src_ready", 64'(src_ready), 64'd1);
        check("rst_dst_valid", 64'(dst_valid), 64'd0);
`ifdef I2S_RX_DC_FIFO_LEVEL_EN
        check("rst_level", 64'(dst_level), 64'd0);
`endif
        #100;
        rstn = 1'b1;

        // Single word, src 1 MHz, dst 50 MHz
        dst_ready = 1'b1;
        @(negedge src_clk);
        src_data  = 32'hA5A5_1234;
        src_valid = 1'b1;
        exp_q.push_back(32'hA5A5_1234);
        @(posedge src_clk);
        #1;
        n = 0;
        while (!dst_valid && n < 10) begin
            @(posedge dst_clk);
            #1;
            n++;
        end
        check("single_lat_le3", 64'(n >= 1 && n <= 3), 64'd1);
        @(negedge src_clk);
        src_valid = 1'b0;
        drain("single_drain", 50);
        repeat (10) @(posedge dst_clk);
        #1;
        check("single_one_beat", 64'(pops), 64'd1);
        check("single_idle", 64'(dst_valid), 64'd0);

        // Fill with consumer stalled; fifth word dropped
        src_half  = 50;
        dst_ready = 1'b0;
        wr(32'h1, 1'b1);
        wr(32'h2, 1'b1);
        wr(32'h3, 1'b1);
        check("fill_ready_3", 64'(src_ready), 64'd1);
        wr(32'h4, 1'b1);
        check("fill_full_4", 64'(src_ready), 64'd0);
        wr(32'h5, 1'b0);
        check("fill_still_full", 64'(src_ready), 64'd0);
        repeat (10) @(posedge dst_clk);
        #1;
        check("fill_valid", 64'(dst_valid), 64'd1);
`ifdef I2S_RX_DC_FIFO_LEVEL_EN
        check("fill_level", 64'(dst_level), 64'd4);
`endif

        // Full release: pop exactly one word
        @(posedge dst_clk);
        #1;
        dst_ready = 1'b1;
        @(posedge dst_clk);
        #1;
        dst_ready = 1'b0;
        n = 0;
        while (!src_ready && n < 10) begin
            @(posedge src_clk);
            #1;
            n++;
        end
        check("release_le3", 64'(n >= 1 && n <= 3), 64'd1);
        wr(32'h6, 1'b1);
        dst_ready = 1'b1;
        drain("fill_drain", 200);

        // Streaming with random consumer, pointers wrap 125 times
        rand_rdy = 1'b1;
        pops0    = pops;
        sent     = 0;
        guard    = 0;
        while (sent < 1000 && guard < 20000) begin
            @(negedge src_clk);
            guard++;
            if (src_ready) begin
                src_data  = 32'h1000_0000 + 32'(sent);
                src_valid = 1'b1;
                exp_q.push_back(32'h1000_0000 + 32'(sent));
                sent++;
            end else begin
                src_valid = 1'b0;
            end
        end
        @(negedge src_clk);
        src_valid = 1'b0;
        check("stream_sent", 64'(sent), 64'd1000);
        drain("stream_drain", 2000);
        check("stream_pops", 64'(pops - pops0), 64'd1000);
        rand_rdy = 1'b0;
        repeat (3) @(posedge dst_clk);
        #2;
        dst_ready = 1'b0;

        // Reset with three words queued
        wr(32'hDEAD_0001, 1'b1);
        wr(32'hDEAD_0002, 1'b1);
        wr(32'hDEAD_0003, 1'b1);
        repeat (10) @(posedge dst_clk);
        #3;
        rstn = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_dst_valid", 64'(dst_valid), 64'd0);
        check("midrst_src_ready", 64'(src_ready), 64'd1);
`ifdef I2S_RX_DC_FIFO_LEVEL_EN
        check("midrst_level", 64'(dst_level), 64'd0);
`endif
        repeat (2) @(posedge src_clk);
        #3;
        rstn      = 1'b1;
        dst_ready = 1'b1;
        repeat (20) @(posedge dst_clk);
        #1;
        check("postrst_empty", 64'(dst_valid), 64'd0);
        wr(32'h0000_0077, 1'b1);
        drain("postrst_drain", 100);

        // dst 10x slower, then src_clk stops with two words queued
        dst_ready = 1'b0;
        dst_half  = 500;
        repeat (2) @(posedge dst_clk);
        wr(32'hC0DE_00C1, 1'b1);
        wr(32'hC0DE_00C2, 1'b1);
        src_run = 1'b0;
        repeat (5) @(posedge dst_clk);
        #1;
        check("stop_valid", 64'(dst_valid), 64'd1);
        dst_ready = 1'b1;
        drain("stop_drain", 20);
        @(posedge dst_clk);
        #1;
        check("stop_empty", 64'(dst_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
